// File: rtl/axi_ifu_rsp.sv
// axi_ifu_rsp: AXI read-channel responder for instruction fetch.
// One AR beat at a time, programmable wait, one 64-bit memory read, one R beat.
// Optional build macro AXI_RSP_RANDOM_DELAY_EN adds 0..3 LFSR-driven extra
// wait cycles per good access to exercise master backpressure handling.
module axi_ifu_rsp #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          ADDR_W    = 16,
  parameter int          LATENCY   = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       io_araddr,
  input  logic              io_arvalid,
  output logic              io_arready,
  output logic              io_rvalid,
  input  logic              io_rready,
  output logic [63:0]       io_rdata,
  output logic [1:0]        io_rresp,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [63:0]       mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_RESP} state_t;

  // Window size in bytes; one extra bit so ADDR_W up to 29 cannot overflow.
  localparam logic [32:0] WIN_BYTES = 33'd8 << ADDR_W;

  state_t            r_state, w_next;
  logic              r_arready;
  logic [8:0]        r_cnt;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_hi;
  logic [63:0]       r_rdata;
  logic [1:0]        r_rresp;

  logic              w_accept;
  logic [31:0]       w_off;
  logic              w_misalign;
  logic              w_oob;
  logic [8:0]        w_cnt_load;

  assign w_accept   = io_arvalid && r_arready;
  assign w_off      = io_araddr - BASE_ADDR;
  assign w_misalign = |io_araddr[1:0];
  assign w_oob      = {1'b0, w_off} >= WIN_BYTES;

`ifdef AXI_RSP_RANDOM_DELAY_EN
  logic [7:0] r_lfsr;
  logic       w_fb;
  assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  // Free-running Fibonacci LFSR (taps 8,6,5,4) supplying extra wait cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_lfsr <= 8'hA5;
    else        r_lfsr <= {r_lfsr[6:0], w_fb};
  end

  assign w_cnt_load = 9'(LATENCY) + {7'd0, r_lfsr[1:0]};
`else
  assign w_cnt_load = 9'(LATENCY);
`endif

  // The memory strobe is a pure decode of WAIT with an expired counter.
  assign mem_en     = (r_state == S_WAIT) && (r_cnt == 9'd0);
  // Address is only driven to the new index during the strobe, otherwise
  // it keeps showing the last index actually presented to memory.
  assign mem_addr   = mem_en ? r_idx : r_mem_addr;
  assign io_arready = r_arready;
  assign io_rvalid  = (r_state == S_RESP);
  assign io_rdata   = r_rdata;
  assign io_rresp   = r_rresp;

  // Next-state decode; errors skip straight to RESP without touching memory.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (w_misalign || w_oob) ? S_RESP : S_WAIT;
      S_WAIT: if (r_cnt == 9'd0) w_next = S_READ;
      S_READ: w_next = S_RESP;
      S_RESP: if (io_rready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register; arready is registered so it stays low through reset and
  // rises only on the first clock spent in IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_arready <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_arready <= (w_next == S_IDLE);
    end
  end

  // Transaction datapath: address latch, wait counter, response capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_hi    <= 1'b0;
      r_rdata <= '0;
      r_rresp <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_hi <= io_araddr[2];
          if (w_misalign) begin
            r_rresp <= 2'b10;
            r_rdata <= '0;
          end else if (w_oob) begin
            r_rresp <= 2'b11;
            r_rdata <= '0;
          end else begin
            r_idx <= w_off[ADDR_W+2:3];
            r_cnt <= w_cnt_load;
          end
        end
        S_WAIT: if (r_cnt != 9'd0) r_cnt <= r_cnt - 9'd1;
        S_READ: begin
          // Upper word is replicated so [31:0] always holds the fetched instruction.
          r_rdata <= r_hi ? {mem_rdata[63:32], mem_rdata[63:32]} : mem_rdata;
          r_rresp <= 2'b00;
        end
        default: ;
      endcase
    end
  end

  // Remember the last index presented with the strobe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      r_mem_addr <= '0;
    else if (mem_en) r_mem_addr <= r_idx;
  end

endmodule
